cpu_fetch_ctrl: RTL and testbench

Fetch sequencer for the CPU's 16-bit program counter. It computes `pc_next` every cycle from the current `pc` and the decode/execute redirect, interrupt, halt and stall inputs. It also owns the interrupt return address (EPC) and a small hardware return-address stack (RAS) for call/return. It sits between the pipeline control logic and the PC register, and drives that register's `pc_next` input.

---
 rtl/cpu_fetch_ctrl_if.sv | 53 +++++
 rtl/cpu_fetch_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_cpu_fetch_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_fetch_ctrl_if.sv
// Fetch-controller bundle: pipeline control side <-> PC sequencer.
// Latency: none; plain wires grouping the request inputs and PC/status outputs.
// Backpressure: none; stall is carried as an ordinary request input.
//
// Signals (direction as seen by the fetch controller, i.e. the slave modport):
//   pc            in  16  current PC (PC register output)
//   stall         in   1  freeze PC and controller state
//   redir_valid   in   1  control-flow redirect this cycle
//   redir_type    in   2  00 jump, 01 call, 10 ret, 11 jump
//   redir_target  in  16  jump/call target
//   irq_req       in   1  level interrupt request
//   reti          in   1  return from interrupt
//   halt_req      in   1  halt instruction executed
//   resume        in   1  leave HALT
//   pc_next       out 16  next PC (combinational)
//   fetch_valid   out  1  current fetch is valid
//   irq_ack       out  1  interrupt entry pulse
//   in_isr        out  1  handler active
//   halted        out  1  in HALT
//   epc           out 16  saved interrupt return PC
//   ras_err       out  1  sticky RAS overflow/underflow
interface cpu_fetch_ctrl_if;
    logic [15:0] pc;
    logic        stall;
    logic        redir_valid;
    logic [1:0]  redir_type;
    logic [15:0] redir_target;
    logic        irq_req;
    logic        reti;
    logic        halt_req;
    logic        resume;
    logic [15:0] pc_next;
    logic        fetch_valid;
    logic        irq_ack;
    logic        in_isr;
    logic        halted;
    logic [15:0] epc;
    logic        ras_err;

    // Pipeline control / PC register side.
    modport master (
        output pc, stall, redir_valid, redir_type, redir_target,
               irq_req, reti, halt_req, resume,
        input  pc_next, fetch_valid, irq_ack, in_isr, halted, epc, ras_err
    );

    // Fetch controller side.
    modport slave (
        input  pc, stall, redir_valid, redir_type, redir_target,
               irq_req, reti, halt_req, resume,
        output pc_next, fetch_valid, irq_ack, in_isr, halted, epc, ras_err
    );
endinterface

// File: rtl/cpu_fetch_ctrl.sv
// PC sequencer: picks next fetch address from redirect/irq/halt/stall, owns EPC and a return-address stack.
// Latency: pc_next, fetch_valid, irq_ack are combinational; state, EPC, RAS and flags update on the deciding edge.
// Backpressure: stall freezes PC and all controller state; requests must be held upstream while stalled.
//
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset (returns to BOOT, empties RAS)
//   fc     cpu_fetch_ctrl_if.slave bundle (pc/request inputs, pc_next/status outputs)
module cpu_fetch_ctrl #(
    parameter logic [15:0] RESET_VEC = 16'h0000,
    parameter logic [15:0] IRQ_VEC   = 16'h0004,
    parameter logic [15:0] PC_INC    = 16'd4,
    parameter int          RAS_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cpu_fetch_ctrl_if.slave       fc
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] RAS_FULL = CW'(RAS_DEPTH);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_ISR  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    state_t         r_state;
    logic           r_halt_from_isr;
    logic           r_in_isr;
    logic           r_halted;
    logic [15:0]    r_epc;
    logic           r_ras_err;

    // RAS: r_ras_top is the next write slot; the newest entry sits at
    // r_ras_top-1. When full, r_ras_top also points at the oldest entry,
    // so a push naturally overwrites it.
    logic [15:0]    r_ras_mem [RAS_DEPTH];
    logic [PW-1:0]  r_ras_top;
    logic [CW-1:0]  r_ras_cnt;

    // ---------------------------------------------------------------
    // Decode
    // ---------------------------------------------------------------
    logic [15:0]    w_pc_inc;
    logic [PW-1:0]  w_top_m1;
    logic [15:0]    w_ras_top_val;
    logic           w_in_run;
    logic           w_in_isr_st;
    logic           w_go;
    logic           w_do_halt;
    logic           w_do_reti;
    logic           w_do_redir;
    logic           w_is_call;
    logic           w_is_ret;
    logic           w_do_call;
    logic           w_do_ret;
    logic           w_ras_empty;
    logic           w_ras_full;
    logic           w_do_pop;
    logic           w_underflow;
    logic           w_do_irq;
    logic [15:0]    w_pc_next;
    logic           w_fetch_valid;

    assign w_pc_inc      = fc.pc + PC_INC;
    assign w_top_m1      = r_ras_top - PW'(1);
    assign w_ras_top_val = r_ras_mem[w_top_m1];

    assign w_in_run    = (r_state == S_RUN);
    assign w_in_isr_st = (r_state == S_ISR);
    assign w_go        = (w_in_run || w_in_isr_st) && !fc.stall;

    // Priority chain: halt > reti (ISR only) > redirect > irq (RUN only).
    assign w_do_halt  = w_go && fc.halt_req;
    assign w_do_reti  = w_go && !fc.halt_req && fc.reti && w_in_isr_st;
    assign w_do_redir = w_go && !fc.halt_req && !w_do_reti && fc.redir_valid;

    assign w_is_call  = (fc.redir_type == 2'b01);
    assign w_is_ret   = (fc.redir_type == 2'b10);
    assign w_do_call  = w_do_redir && w_is_call;
    assign w_do_ret   = w_do_redir && w_is_ret;

    assign w_ras_empty = (r_ras_cnt == '0);
    assign w_ras_full  = (r_ras_cnt == RAS_FULL);
    assign w_do_pop    = w_do_ret && !w_ras_empty;
    assign w_underflow = w_do_ret && w_ras_empty;

    // reti is inert in RUN, so it does not defer an interrupt there; only
    // halt and redirect do. A deferred level irq is simply seen again later.
    assign w_do_irq = w_go && w_in_run && !fc.halt_req && !fc.redir_valid && fc.irq_req;

    always_comb begin
        w_pc_next     = fc.pc;
        w_fetch_valid = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_pc_next = RESET_VEC;
            end
            S_HALT: begin
                if (fc.resume) begin
                    w_pc_next = w_pc_inc;
                end
            end
            default: begin
                if (!fc.stall) begin
                    w_fetch_valid = 1'b1;
                    if (fc.halt_req) begin
                        w_pc_next = fc.pc;
                    end else if (w_do_reti) begin
                        w_pc_next = r_epc;
                    end else if (fc.redir_valid) begin
                        if (w_is_ret) begin
                            // Underflow falls back to a sequential fetch.
                            w_pc_next = w_ras_empty ? w_pc_inc : w_ras_top_val;
                        end else begin
                            w_pc_next = fc.redir_target;
                        end
                    end else if (w_do_irq) begin
                        w_pc_next = IRQ_VEC;
                    end else begin
                        w_pc_next = w_pc_inc;
                    end
                end
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Control FSM with registered status outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_BOOT;
            r_halt_from_isr <= 1'b0;
            r_in_isr        <= 1'b0;
            r_halted        <= 1'b0;
            r_epc           <= 16'h0000;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state  <= S_RUN;
                    r_in_isr <= 1'b0;
                    r_halted <= 1'b0;
                end
                S_RUN, S_ISR: begin
                    if (w_do_halt) begin
                        r_state         <= S_HALT;
                        r_halt_from_isr <= w_in_isr_st;
                        r_halted        <= 1'b1;
                        r_in_isr        <= 1'b0;
                    end else if (w_do_reti) begin
                        r_state  <= S_RUN;
                        r_in_isr <= 1'b0;
                    end else if (w_do_irq) begin
                        r_state  <= S_ISR;
                        r_in_isr <= 1'b1;
                        r_epc    <= fc.pc;
                    end
                end
                S_HALT: begin
                    if (fc.resume) begin
                        r_state  <= r_halt_from_isr ? S_ISR : S_RUN;
                        r_in_isr <= r_halt_from_isr;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_BOOT;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Return-address stack pointers and sticky error
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ras_top <= '0;
            r_ras_cnt <= '0;
            r_ras_err <= 1'b0;
        end else begin
            if (w_do_call) begin
                r_ras_top <= r_ras_top + PW'(1);
                if (w_ras_full) begin
                    r_ras_err <= 1'b1;
                end else begin
                    r_ras_cnt <= r_ras_cnt + CW'(1);
                end
            end
            if (w_do_pop) begin
                r_ras_top <= w_top_m1;
                r_ras_cnt <= r_ras_cnt - CW'(1);
            end
            if (w_underflow) begin
                r_ras_err <= 1'b1;
            end
        end
    end

    // Entry storage needs no reset: the count alone defines validity.
    always_ff @(posedge clk) begin
        if (w_do_call) begin
            r_ras_mem[r_ras_top] <= w_pc_inc;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign fc.pc_next     = w_pc_next;
    assign fc.fetch_valid = w_fetch_valid;
    assign fc.irq_ack     = w_do_irq;
    assign fc.in_isr      = r_in_isr;
    assign fc.halted      = r_halted;
    assign fc.epc         = r_epc;
    assign fc.ras_err     = r_ras_err;

endmodule

// File: tb/tb_cpu_fetch_ctrl.sv
// Bench for cpu_fetch_ctrl: directed scenarios then random traffic against a queue-based reference model.
// Latency: expected record pushed at stimulus time, popped and compared at the following falling edge.
// Backpressure: stall is exercised as a random and directed input.
module tb_cpu_fetch_ctrl;

    localparam logic [15:0] RESET_VEC = 16'h0000;
    localparam logic [15:0] IRQ_VEC   = 16'h0004;
    localparam logic [15:0] PC_INC    = 16'd4;
    localparam int          RAS_DEPTH = 4;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_ISR  = 2;
    localparam int M_HALT = 3;

    typedef struct packed {
        bit          rstn;
        bit          stall;
        bit          rv;
        logic [1:0]  rt;
        logic [15:0] tgt;
        bit          irq;
        bit          reti;
        bit          halt;
        bit          resume;
    } stim_t;

    typedef struct packed {
        logic [15:0] pc_next;
        logic        fv;
        logic        ack;
        logic        in_isr;
        logic        halted;
        logic [15:0] epc;
        logic        ras_err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cpu_fetch_ctrl_if fc ();

    cpu_fetch_ctrl #(
        .RESET_VEC (RESET_VEC),
        .IRQ_VEC   (IRQ_VEC),
        .PC_INC    (PC_INC),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fc    (fc)
    );

    int n_chk  = 0;
    int n_fail = 0;

    exp_t exp_q[$];

    // Reference model: mode number, saved return, and the RAS as a plain
    // list whose back is the newest entry.
    int          m_mode;
    bit          m_hfi;
    logic [15:0] m_epc;
    bit          m_err;
    logic [15:0] m_ras[$];
    logic [15:0] m_pc;

    int          n_mode;
    bit          n_hfi;
    logic [15:0] n_epc;
    bit          n_err;
    logic [15:0] n_ras[$];
    logic [15:0] n_pc;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rstn = 1'b1;
        return s;
    endfunction

    task automatic model_reset();
        m_mode = M_BOOT;
        m_hfi  = 1'b0;
        m_epc  = 16'h0000;
        m_err  = 1'b0;
        m_ras.delete();
        m_pc   = RESET_VEC;
    endtask

    // Drive one cycle's inputs and work out what the controller must do.
    task automatic drive_decide(input stim_t s);
        exp_t e;
        logic [15:0] seq;
        if (!s.rstn) model_reset();
        rst_n           = s.rstn;
        fc.pc           = m_pc;
        fc.stall        = s.stall;
        fc.redir_valid  = s.rv;
        fc.redir_type   = s.rt;
        fc.redir_target = s.tgt;
        fc.irq_req      = s.irq;
        fc.reti         = s.reti;
        fc.halt_req     = s.halt;
        fc.resume       = s.resume;

        seq    = m_pc + PC_INC;
        n_mode = m_mode;
        n_hfi  = m_hfi;
        n_epc  = m_epc;
        n_err  = m_err;
        n_ras  = m_ras;
        e.pc_next = m_pc;
        e.fv      = 1'b0;
        e.ack     = 1'b0;

        if (!s.rstn) begin
            e.pc_next = RESET_VEC;
        end else if (m_mode == M_BOOT) begin
            e.pc_next = RESET_VEC;
            n_mode    = M_RUN;
        end else if (m_mode == M_HALT) begin
            if (s.resume) begin
                e.pc_next = seq;
                n_mode    = m_hfi ? M_ISR : M_RUN;
            end
        end else if (!s.stall) begin
            e.fv = 1'b1;
            if (s.halt) begin
                e.pc_next = m_pc;
                n_mode    = M_HALT;
                n_hfi     = (m_mode == M_ISR);
            end else if (s.reti && m_mode == M_ISR) begin
                e.pc_next = m_epc;
                n_mode    = M_RUN;
            end else if (s.rv) begin
                if (s.rt == 2'b01) begin
                    if (n_ras.size() == RAS_DEPTH) begin
                        void'(n_ras.pop_front());
                        n_err = 1'b1;
                    end
                    n_ras.push_back(seq);
                    e.pc_next = s.tgt;
                end else if (s.rt == 2'b10) begin
                    if (n_ras.size() == 0) begin
                        e.pc_next = seq;
                        n_err     = 1'b1;
                    end else begin
                        e.pc_next = n_ras.pop_back();
                    end
                end else begin
                    e.pc_next = s.tgt;
                end
            end else if (s.irq && m_mode == M_RUN) begin
                e.pc_next = IRQ_VEC;
                e.ack     = 1'b1;
                n_epc     = m_pc;
                n_mode    = M_ISR;
            end else begin
                e.pc_next = seq;
            end
        end

        e.in_isr  = (m_mode == M_ISR);
        e.halted  = (m_mode == M_HALT);
        e.epc     = m_epc;
        e.ras_err = m_err;
        n_pc      = e.pc_next;
        exp_q.push_back(e);
    endtask

    task automatic commit();
        m_mode = n_mode;
        m_hfi  = n_hfi;
        m_epc  = n_epc;
        m_err  = n_err;
        m_ras  = n_ras;
        m_pc   = n_pc;
    endtask

    task automatic cycle(input stim_t s);
        drive_decide(s);
        @(posedge clk);
        #1;
        commit();
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every falling edge the DUT presents a full output set.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_next",     fc.pc_next,            e.pc_next);
                chk("fetch_valid", 16'(fc.fetch_valid),   16'(e.fv));
                chk("irq_ack",     16'(fc.irq_ack),       16'(e.ack));
                chk("in_isr",      16'(fc.in_isr),        16'(e.in_isr));
                chk("halted",      16'(fc.halted),        16'(e.halted));
                chk("epc",         fc.epc,                e.epc);
                chk("ras_err",     16'(fc.ras_err),       16'(e.ras_err));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        int guard;
        logic [15:0] r16;

        rst_n = 1'b0;
        fc.pc = '0; fc.stall = 1'b0; fc.redir_valid = 1'b0; fc.redir_type = '0;
        fc.redir_target = '0; fc.irq_req = 1'b0; fc.reti = 1'b0;
        fc.halt_req = 1'b0; fc.resume = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset held, then BOOT and free run.
        s = idle(); s.rstn = 1'b0;
        cycle(s);
        cycle(s);
        guard = 0;
        while (m_pc != 16'h0010 && guard < 20) begin
            cycle(idle());
            guard++;
        end

        // Call at 0010 to 0100, then return.
        s = idle(); s.rv = 1'b1; s.rt = 2'b01; s.tgt = 16'h0100;
        cycle(s);
        cycle(idle());
        s = idle(); s.rv = 1'b1; s.rt = 2'b10;
        cycle(s);

        // Five nested calls overflow a 4-deep stack; five rets.
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.rv = 1'b1; s.rt = 2'b01; s.tgt = 16'(16'h1000 * (i + 1));
            cycle(s);
        end
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.rv = 1'b1; s.rt = 2'b10;
            cycle(s);
        end

        // IRQ at 0020, second IRQ in ISR ignored, reti back.
        s = idle(); s.rv = 1'b1; s.tgt = 16'h0020;
        cycle(s);
        s = idle(); s.irq = 1'b1;
        cycle(s);
        cycle(s);
        cycle(s);
        s = idle(); s.reti = 1'b1;
        cycle(s);

        // IRQ coincident with a jump: jump first, IRQ next cycle.
        s = idle(); s.irq = 1'b1; s.rv = 1'b1; s.tgt = 16'h0200;
        cycle(s);
        s = idle(); s.irq = 1'b1;
        cycle(s);
        s = idle(); s.reti = 1'b1;
        cycle(s);

        // IRQ held through three stalled cycles.
        s = idle(); s.irq = 1'b1; s.stall = 1'b1;
        for (int i = 0; i < 3; i++) cycle(s);
        s.stall = 1'b0;
        cycle(s);

        // Halt inside ISR at 0008, ignored irq/stall while halted, resume, reti.
        cycle(idle());
        if (m_pc == 16'h0008) begin
            s = idle(); s.halt = 1'b1;
            cycle(s);
        end
        s = idle(); s.irq = 1'b1; s.stall = 1'b1;
        cycle(s);
        cycle(idle());
        s = idle(); s.resume = 1'b1;
        cycle(s);
        cycle(idle());
        s = idle(); s.reti = 1'b1;
        cycle(s);

        // Wrap from FFFC.
        m_pc = 16'hFFFC;
        cycle(idle());
        cycle(idle());

        // Asynchronous reset in the middle of an ISR.
        s = idle(); s.irq = 1'b1;
        cycle(s);
        cycle(idle());
        s = idle(); s.rstn = 1'b0;
        cycle(s);
        cycle(s);

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            s = idle();
            if ($urandom_range(0, 399) == 0) s.rstn = 1'b0;
            s.stall  = ($urandom_range(0, 99) < 15);
            s.rv     = ($urandom_range(0, 99) < 30);
            s.rt     = 2'($urandom_range(0, 3));
            r16      = 16'($urandom_range(0, 65535));
            s.tgt    = r16 & 16'hFFFC;
            s.irq    = ($urandom_range(0, 99) < 20);
            s.reti   = ($urandom_range(0, 99) < 12);
            s.halt   = ($urandom_range(0, 99) < 4);
            s.resume = ($urandom_range(0, 99) < 35);
            if ($urandom_range(0, 99) == 0) m_pc = 16'hFFF8;
            cycle(s);
        end

        @(negedge clk);
        #1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
